// File: rtl/mat_mult_seq_if.sv
// mat_mult_seq_if: request/response bundle between a mat_mult initiator and
// the sequential mat_mult responder. The initiator drives the master modport.
interface mat_mult_seq_if #(
  parameter int N  = 6,
  parameter int DW = 27
);
  logic                        en;
  logic                        start;
  logic                        mat_mode;
  logic [N-1:0][N-1:0][DW-1:0] dataa;
  logic [N-1:0][N-1:0][DW-1:0] datab;
  logic                        busy;
  logic                        done;
  logic [N-1:0][N-1:0][DW-1:0] result;
  logic                        ovf;

  modport master (
    output en, start, mat_mode, dataa, datab,
    input  busy, done, result, ovf
  );

  modport slave (
    input  en, start, mat_mode, dataa, datab,
    output busy, done, result, ovf
  );
endinterface

// File: rtl/mat_mult_seq.sv
// mat_mult_seq: sequential 6x6 fixed-point matrix / element-wise multiplier
// built around a single DWxDW MAC. Operands are captured on accept, each
// result element is accumulated over one product per cycle, written back,
// and done pulses once the whole matrix is coherent.
// Optional feature macro: MAT_MULT_SEQ_SATURATE_EN (clamp on write-back and
// report clamps on ovf; otherwise the write-back slice wraps and ovf is 0).
module mat_mult_seq #(
  parameter int DW   = 27,
  parameter int FRAC = 16,
  parameter int N    = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  mat_mult_seq_if.slave bus
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * DW;
  // Six guard bits above the full product width: N <= 64 products of any
  // DW-bit operands can never overflow the accumulator.
  localparam int AW = PW + 6;

  typedef enum logic [1:0] {IDLE, MAC, WB, DONE} state_t;

  state_t                      state, state_nx;
  logic [CW-1:0]               i, j, k;
  logic                        mode;
  logic                        drain;
  logic                        prod_vld;
  logic [N-1:0][N-1:0][DW-1:0] ra, rb;
  logic [N-1:0][N-1:0][DW-1:0] res;
  logic signed [PW-1:0]        prod_r;
  logic signed [AW-1:0]        acc;
  logic [DW-1:0]               a_sel, b_sel;
  logic signed [PW-1:0]        a_x, b_x;
  logic                        last_term, last_elem;
  logic [DW-1:0]               wb_val;
  logic                        wb_clamp;

  // Operand selection: matrix mode walks a[i][k]*b[k][j]; array mode uses
  // the single term a[i][j]*b[i][j].
  assign a_sel     = ra[i][mode ? k : j];
  assign b_sel     = mode ? rb[k][j] : rb[i][j];
  assign a_x       = {{DW{a_sel[DW-1]}}, a_sel};
  assign b_x       = {{DW{b_sel[DW-1]}}, b_sel};
  assign last_term = mode ? (k == CW'(N-1)) : 1'b1;
  assign last_elem = (i == CW'(N-1)) && (j == CW'(N-1));

  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);
  assign bus.result = res;

`ifdef MAT_MULT_SEQ_SATURATE_EN
  logic                   ovf_r;
  logic [AW-FRAC-DW:0]    acc_hi;
  logic                   sat_pos, sat_neg;

  // Everything from the result sign bit upward must match the acc sign,
  // otherwise acc>>FRAC is outside the DW-bit range and gets clamped.
  assign acc_hi   = acc[AW-1:FRAC+DW-1];
  assign sat_pos  = ~acc[AW-1] & (|acc_hi);
  assign sat_neg  =  acc[AW-1] & ~(&acc_hi);
  assign wb_clamp = sat_pos | sat_neg;

  // Clamp to the signed DW-bit range, else plain slice (floor of acc/2^FRAC).
  always_comb begin
    wb_val = acc[FRAC+DW-1:FRAC];
    if (sat_pos)      wb_val = {1'b0, {(DW-1){1'b1}}};
    else if (sat_neg) wb_val = {1'b1, {(DW-1){1'b0}}};
  end

  // Sticky clamp flag, cleared by each new accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf_r <= 1'b0;
    else if (bus.en) begin
      if (state == IDLE && bus.start) ovf_r <= 1'b0;
      else if (state == WB && wb_clamp) ovf_r <= 1'b1;
    end
  end

  assign bus.ovf = ovf_r;
`else
  assign wb_val   = acc[FRAC+DW-1:FRAC];
  assign wb_clamp = 1'b0;
  assign bus.ovf  = 1'b0;
`endif

  // State register; en low freezes the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      state <= IDLE;
    else if (bus.en) state <= state_nx;
  end

  // Next-state: MAC stays until its drain cycle, WB loops back per element.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start) state_nx = MAC;
      MAC:     if (drain) state_nx = WB;
      WB:      state_nx = last_elem ? DONE : MAC;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: operand capture, MAC pipeline, counters and result write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra       <= '0;
      rb       <= '0;
      res      <= '0;
      mode     <= 1'b0;
      i        <= '0;
      j        <= '0;
      k        <= '0;
      drain    <= 1'b0;
      prod_vld <= 1'b0;
      prod_r   <= '0;
      acc      <= '0;
    end else if (bus.en) begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            ra       <= bus.dataa;
            rb       <= bus.datab;
            mode     <= bus.mat_mode;
            i        <= '0;
            j        <= '0;
            k        <= '0;
            drain    <= 1'b0;
            prod_vld <= 1'b0;
            acc      <= '0;
          end
        end
        MAC: begin
          // prod_r lags one cycle; the drain cycle adds the final product.
          if (prod_vld) acc <= acc + {{(AW-PW){prod_r[PW-1]}}, prod_r};
          prod_vld <= ~drain;
          if (!drain) begin
            prod_r <= a_x * b_x;
            if (last_term) drain <= 1'b1;
            else           k     <= k + CW'(1);
          end else begin
            drain <= 1'b0;
            k     <= '0;
          end
        end
        WB: begin
          res[i][j] <= wb_val;
          acc       <= '0;
          if (last_elem) begin
            i <= '0;
            j <= '0;
          end else if (j == CW'(N-1)) begin
            j <= '0;
            i <= i + CW'(1);
          end else begin
            j <= j + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mat_mult_seq.sv
// tb_mat_mult_seq: directed bench for mat_mult_seq. Each request pushes its
// model-computed expectation onto a scoreboard queue; each done pops it and
// compares latency, result matrix and ovf.
module tb_mat_mult_seq;
  localparam int DW   = 27;
  localparam int FRAC = 16;
  localparam int N    = 6;
  localparam int LAT_MAT = 289;
  localparam int LAT_ARR = 109;

  typedef logic [N-1:0][N-1:0][DW-1:0] mat_t;
  typedef struct {
    mat_t res;
    int   lat;
    logic ovf;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];

  mat_mult_seq_if #(.N(N), .DW(DW)) bus ();

  mat_mult_seq #(.DW(DW), .FRAC(FRAC), .N(N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_mat(input string tag, input mat_t got, input mat_t exp);
    int fr = 0;
    int fc = 0;
    bit found = 0;
    checks++;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        if (!found && got[r][c] !== exp[r][c]) begin
          fr = r; fc = c; found = 1;
        end
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s [%0d][%0d]: observed %h expected %h", tag, fr, fc, got[fr][fc], exp[fr][fc]);
    end
  endtask

  // Reference: wide signed sum, floor shift, then wrap or clamp to DW bits.
  function automatic exp_t mk_exp(input mat_t a, input mat_t b, input logic mm);
    exp_t   e;
    longint s, sh;
    logic [63:0] t;
    e.ovf = 1'b0;
    e.lat = mm ? LAT_MAT : LAT_ARR;
    e.res = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        s = 0;
        if (mm)
          for (int q = 0; q < N; q++)
            s += longint'($signed(a[r][q])) * longint'($signed(b[q][c]));
        else
          s = longint'($signed(a[r][c])) * longint'($signed(b[r][c]));
        sh = s >>> FRAC;
        t  = sh;
`ifdef MAT_MULT_SEQ_SATURATE_EN
        if (sh > longint'((1 << (DW-1)) - 1)) begin
          e.res[r][c] = {1'b0, {(DW-1){1'b1}}}; e.ovf = 1'b1;
        end else if (sh < -longint'(1 << (DW-1))) begin
          e.res[r][c] = {1'b1, {(DW-1){1'b0}}}; e.ovf = 1'b1;
        end else
          e.res[r][c] = t[DW-1:0];
`else
        e.res[r][c] = t[DW-1:0];
`endif
      end
    return e;
  endfunction

  function automatic mat_t rnd_mat();
    mat_t m;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        m[r][c] = DW'($urandom());
    return m;
  endfunction

  function automatic mat_t fill(input logic [DW-1:0] v);
    mat_t m;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        m[r][c] = v;
    return m;
  endfunction

  // Drive one start pulse; returns at the negedge after the accept edge.
  // Operands are scrambled afterwards: they must only be sampled on accept.
  task automatic kick(input mat_t a, input mat_t b, input logic mm);
    @(negedge clk);
    bus.dataa = a; bus.datab = b; bus.mat_mode = mm; bus.start = 1'b1;
    sbq.push_back(mk_exp(a, b, mm));
    @(negedge clk);
    bus.start = 1'b0;
    bus.dataa = ~a; bus.datab = ~b; bus.mat_mode = ~mm;
  endtask

  // Wait (bounded) for done counting edges from accept (accept edge = 1),
  // optionally stalling en mid-run, holding start high, or freezing in DONE.
  task automatic wait_done(input string tag, input int stall_at, input int stall_len,
                           input bit hold, input int dstall);
    int   lat = 1;
    exp_t e;
    while (!bus.done && lat < 1000) begin
      bus.start = hold;
      if (stall_len > 0 && lat == stall_at)             bus.en = 1'b0;
      if (stall_len > 0 && lat == stall_at + stall_len) bus.en = 1'b1;
      @(negedge clk);
      lat++;
    end
    bus.en = 1'b1;
    chk({tag, " sb nonempty"}, 32'(sbq.size() > 0), 32'd1);
    if (sbq.size() == 0) return;
    e = sbq.pop_front();
    chk({tag, " latency"}, 32'(lat), 32'(e.lat + stall_len));
    chk_mat({tag, " result"}, bus.result, e.res);
    chk({tag, " ovf"}, 32'(bus.ovf), 32'(e.ovf));
    chk({tag, " busy at done"}, 32'(bus.busy), 32'd1);
    if (dstall > 0) begin
      bus.en = 1'b0;
      repeat (dstall) @(negedge clk);
      chk({tag, " done frozen"}, 32'(bus.done), 32'd1);
      bus.en = 1'b1;
    end
    @(negedge clk);
    chk({tag, " done after"}, 32'(bus.done), 32'd0);
    chk({tag, " busy after"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    mat_t a, b, id;
    exp_t e;
    bus.en = 1'b1; bus.start = 1'b0; bus.mat_mode = 1'b0;
    bus.dataa = '0; bus.datab = '0;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset ovf",  32'(bus.ovf),  32'd0);
    chk_mat("reset result", bus.result, '0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // 1: identity times random, matrix mode
    id = '0;
    for (int d = 0; d < N; d++) id[d][d] = 27'h0010000;
    b = rnd_mat();
    kick(id, b, 1'b1);
    wait_done("t1", 0, 0, 0, 0);
    chk_mat("t1 result==B", bus.result, b);

    // 2: element-wise 2.0 * -1.5, with en low while in DONE
    kick(fill(27'h0020000), fill(27'h7FE8000), 1'b0);
    wait_done("t2", 0, 0, 0, 3);
    chk_mat("t2 result==-3.0", bus.result, fill(27'h7FD0000));

    // 3: start held high while busy; next accept only after DONE
    a = rnd_mat(); b = rnd_mat();
    kick(a, b, 1'b1);
    wait_done("t3", 0, 0, 1, 0);
    a = rnd_mat(); b = rnd_mat();
    bus.dataa = a; bus.datab = b; bus.mat_mode = 1'b0;
    sbq.push_back(mk_exp(a, b, 1'b0));
    @(negedge clk);
    chk("t3 re-accept busy", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    wait_done("t3b", 0, 0, 0, 0);

    // 4: same random operands unstalled then stalled 10 cycles mid-MAC
    a = rnd_mat(); b = rnd_mat();
    kick(a, b, 1'b1);
    wait_done("t4 nostall", 0, 0, 0, 0);
    kick(a, b, 1'b1);
    wait_done("t4 stall", 50, 10, 0, 0);

    // 5: async reset mid-operation, then a full run
    kick(rnd_mat(), rnd_mat(), 1'b1);
    repeat (99) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5 busy", 32'(bus.busy), 32'd0);
    chk("t5 done", 32'(bus.done), 32'd0);
    chk_mat("t5 result cleared", bus.result, '0);
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    a = rnd_mat(); b = rnd_mat();
    kick(a, b, 1'b1);
    wait_done("t5 rerun", 0, 0, 0, 0);

    // 6: large operands overflow the DW-bit result (clamp or wrap per build)
    kick(fill(27'h1000000), fill(27'h1000000), 1'b1);
    wait_done("t6", 0, 0, 0, 0);
    e = mk_exp(fill(27'h1000000), fill(27'h1000000), 1'b1);
`ifdef MAT_MULT_SEQ_SATURATE_EN
    chk("t6 sat elem", 32'(bus.result[2][3]), 32'h3FFFFFF);
    chk("t6 sat ovf", 32'(bus.ovf), 32'd1);
`else
    chk("t6 wrap elem", 32'(bus.result[2][3]), 32'h0);
    chk("t6 wrap ovf", 32'(bus.ovf), 32'd0);
`endif
    chk("t6 model ovf", 32'(bus.ovf), 32'(e.ovf));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
